// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - state encoding, ALU function codes and step count for mul_seq
package mul_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NEG_A,
    ST_NEG_B,
    ST_ITER,
    ST_NEG_LO,
    ST_NEG_HI,
    ST_DONE
  } state_t;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_NOR = 6'b010001;

  localparam int MUL_STEPS = 32;

endpackage

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - 32x32->64 shift-add multiplier that borrows the shared ALU for every step
// Optional feature: MUL_SEQ_SIGNED_EN enables signed operands and the four negate states.
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sign,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        alu_req,
  input  logic        alu_grant,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_sign,
  output logic [5:0]  alu_fun,
  input  logic [31:0] alu_s
);

  state_t      state, state_nxt;
  logic [31:0] mcand, mcand_nxt;
  logic [31:0] hi_nxt, lo_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic [31:0] addend;
  logic        carry;

`ifdef MUL_SEQ_SIGNED_EN
  logic neg_res, neg_res_nxt;
  logic lo_zero, lo_zero_nxt;
  logic sgn_a, sgn_b;
  assign sgn_a = sign & a[31];
  assign sgn_b = sign & b[31];
`else
  logic sign_unused;
  assign sign_unused = sign;
`endif

  assign alu_sign = 1'b0;
  assign addend   = lo[0] ? mcand : 32'd0;
  // Carry-out of hi + addend recovered from the operand and sum MSBs.
  assign carry    = (hi[31] & addend[31]) | ((hi[31] | addend[31]) & ~alu_s[31]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
`ifdef MUL_SEQ_SIGNED_EN
      neg_res <= 1'b0;
      lo_zero <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      mcand   <= mcand_nxt;
      hi      <= hi_nxt;
      lo      <= lo_nxt;
      cnt     <= cnt_nxt;
`ifdef MUL_SEQ_SIGNED_EN
      neg_res <= neg_res_nxt;
      lo_zero <= lo_zero_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    mcand_nxt   = mcand;
    hi_nxt      = hi;
    lo_nxt      = lo;
    cnt_nxt     = cnt;
`ifdef MUL_SEQ_SIGNED_EN
    neg_res_nxt = neg_res;
    lo_zero_nxt = lo_zero;
`endif
    busy        = 1'b1;
    done        = 1'b0;
    alu_req     = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_fun     = ALU_ADD;

    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          mcand_nxt = a;
          lo_nxt    = b;
          hi_nxt    = '0;
          cnt_nxt   = '0;
`ifdef MUL_SEQ_SIGNED_EN
          neg_res_nxt = sgn_a ^ sgn_b;
          if (sgn_a)      state_nxt = ST_NEG_A;
          else if (sgn_b) state_nxt = ST_NEG_B;
          else            state_nxt = ST_ITER;
`else
          state_nxt = ST_ITER;
`endif
        end
      end

`ifdef MUL_SEQ_SIGNED_EN
      ST_NEG_A: begin
        alu_req = 1'b1;
        alu_b   = mcand;
        alu_fun = ALU_SUB;
        if (alu_grant) begin
          mcand_nxt = alu_s;
          // lo still holds the raw multiplier here
          state_nxt = lo[31] ? ST_NEG_B : ST_ITER;
        end
      end

      ST_NEG_B: begin
        alu_req = 1'b1;
        alu_b   = lo;
        alu_fun = ALU_SUB;
        if (alu_grant) begin
          lo_nxt    = alu_s;
          state_nxt = ST_ITER;
        end
      end
`endif

      ST_ITER: begin
        alu_req = 1'b1;
        alu_a   = hi;
        alu_b   = addend;
        alu_fun = ALU_ADD;
        if (alu_grant) begin
          hi_nxt  = {carry, alu_s[31:1]};
          lo_nxt  = {alu_s[0], lo[31:1]};
          cnt_nxt = cnt + 6'd1;
          if (cnt == 6'(MUL_STEPS - 1)) begin
`ifdef MUL_SEQ_SIGNED_EN
            state_nxt = neg_res ? ST_NEG_LO : ST_DONE;
`else
            state_nxt = ST_DONE;
`endif
          end
        end
      end

`ifdef MUL_SEQ_SIGNED_EN
      ST_NEG_LO: begin
        alu_req = 1'b1;
        alu_b   = lo;
        alu_fun = ALU_SUB;
        if (alu_grant) begin
          lo_zero_nxt = (lo == 32'd0);
          lo_nxt      = alu_s;
          state_nxt   = ST_NEG_HI;
        end
      end

      // 64-bit negate: hi borrows only when lo was zero, otherwise it is just inverted.
      ST_NEG_HI: begin
        alu_req = 1'b1;
        if (lo_zero) begin
          alu_b   = hi;
          alu_fun = ALU_SUB;
        end else begin
          alu_a   = hi;
          alu_b   = hi;
          alu_fun = ALU_NOR;
        end
        if (alu_grant) begin
          hi_nxt    = alu_s;
          state_nxt = ST_DONE;
        end
      end
`endif

      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - randomized self-checking bench for mul_seq with an arithmetic reference model
module tb_mul_seq;

`ifdef MUL_SEQ_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sign = 1'b0;
  logic        busy, done, alu_req, alu_sign;
  logic [31:0] hi, lo, alu_a, alu_b, alu_s;
  logic        alu_grant = 1'b1;
  logic [5:0]  alu_fun;

  int checks = 0;
  int failures = 0;

  mul_seq dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .sign(sign),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_req(alu_req), .alu_grant(alu_grant), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sign(alu_sign), .alu_fun(alu_fun), .alu_s(alu_s)
  );

  always #5 clk = ~clk;

  // Shared single-cycle ALU
  always_comb begin
    alu_s = '0;
    case (alu_fun)
      6'b000000: alu_s = alu_a + alu_b;
      6'b000001: alu_s = alu_a - alu_b;
      6'b010001: alu_s = ~(alu_a | alu_b);
      default:   alu_s = '0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_product(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] ex, ey;
    if (SIGNED_EN && s) begin
      ex = {{32{x[31]}}, x};
      ey = {{32{y[31]}}, y};
    end else begin
      ex = {32'd0, x};
      ey = {32'd0, y};
    end
    return ex * ey;
  endfunction

  // ALU cycles needed: 32 shift-add steps plus each operand/result negation
  function automatic int ref_alu_cycles(input logic [31:0] x, input logic [31:0] y, input logic s);
    if (!(SIGNED_EN && s)) return 32;
    return 32 + int'(x[31]) + int'(y[31]) + ((x[31] ^ y[31]) ? 2 : 0);
  endfunction

  typedef enum {M_IDLE, M_WORK, M_DONE} mphase_t;
  mphase_t     mphase = M_IDLE;
  int          rem = 0;
  logic [63:0] mprod = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mphase = M_IDLE;
      mprod  = '0;
    end else begin
      case (mphase)
        M_IDLE: if (start) begin
          mprod  = ref_product(a, b, sign);
          rem    = ref_alu_cycles(a, b, sign);
          mphase = M_WORK;
        end
        M_WORK: if (alu_grant) begin
          rem--;
          if (rem == 0) mphase = M_DONE;
        end
        default: mphase = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("busy", {63'd0, busy}, {63'd0, mphase != M_IDLE});
    chk("done", {63'd0, done}, {63'd0, mphase == M_DONE});
    chk("alu_req", {63'd0, alu_req}, {63'd0, mphase == M_WORK});
    chk("alu_sign", {63'd0, alu_sign}, 64'd0);
    if (mphase != M_WORK) begin
      chk("hilo_model", {hi, lo}, mprod);
      chk("alu_idle_drive", {alu_a, alu_b}, 64'd0);
      chk("alu_fun_idle", {58'd0, alu_fun}, 64'd0);
    end
  end

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                        input int gpct, input int stall_at, input int stall_len,
                        input int restart_at, output int lat, output logic [63:0] res);
    int n;
    bit seen;
    logic [63:0] frozen;
    @(negedge clk);
    a = ta; b = tb; sign = ts; start = 1'b1; alu_grant = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; seen = 0; frozen = '0;
    while (!seen && n < 400) begin
      if (done) seen = 1;
      else begin
        if (stall_len > 0 && n == stall_at) frozen = {hi, lo};
        if (stall_len > 0 && n == stall_at + stall_len) chk("stall_freeze", {hi, lo}, frozen);
        start = (n == restart_at);
        if (n == restart_at) begin
          a = ~ta; b = tb + 32'd1; sign = ~ts;
        end
        if (n >= stall_at && n < stall_at + stall_len) alu_grant = 1'b0;
        else alu_grant = ($urandom_range(99) < gpct);
        @(negedge clk);
        n++;
      end
    end
    alu_grant = 1'b1;
    start = 1'b0;
    chk("done_seen", {63'd0, seen}, 64'd1);
    lat = n;
    res = {hi, lo};
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    int pulses;
    logic [63:0] res;
    logic [31:0] ra, rb;
    logic rs;

    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("reset_flags", {61'd0, busy, done, alu_req}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_alu", {alu_a, alu_b}, 64'd0);

    run_op(32'd3, 32'd5, 1'b0, 100, -1, 0, -1, lat, res);
    chk("u3x5_lat", lat, 32);
    chk("u3x5_res", res, 64'd15);
    @(negedge clk);
    chk("u3x5_busy_after", {63'd0, busy}, 64'd0);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 100, -1, 0, -1, lat, res);
    chk("umax_lat", lat, 32);
    chk("umax_res", res, 64'hFFFF_FFFE_0000_0001);

    run_op(32'hFFFF_FFFE, 32'd3, 1'b1, 100, -1, 0, -1, lat, res);
    chk("s_m2x3_lat", lat, SIGNED_EN ? 35 : 32);
    chk("s_m2x3_res", res, SIGNED_EN ? 64'hFFFF_FFFF_FFFF_FFFA : 64'h0000_0002_FFFF_FFFA);

    run_op(32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1, 100, -1, 0, -1, lat, res);
    chk("s_m2xm3_lat", lat, SIGNED_EN ? 34 : 32);
    chk("s_m2xm3_res", res, SIGNED_EN ? 64'd6 : 64'hFFFF_FFFB_0000_0006);

    run_op(32'h8000_0000, 32'd1, 1'b1, 100, -1, 0, -1, lat, res);
    chk("s_min_lat", lat, SIGNED_EN ? 35 : 32);
    chk("s_min_res", res, SIGNED_EN ? 64'hFFFF_FFFF_8000_0000 : 64'h0000_0000_8000_0000);

    run_op(32'd7, 32'd9, 1'b0, 100, 10, 5, -1, lat, res);
    chk("stall_lat", lat, 37);
    chk("stall_res", res, 64'd63);

    run_op(32'd100, 32'd200, 1'b0, 100, -1, 0, 5, lat, res);
    chk("restart_lat", lat, 32);
    chk("restart_res", res, 64'd20000);

    // Reset mid-operation
    @(negedge clk);
    a = 32'd1234; b = 32'd5678; sign = 1'b0; start = 1'b1; alu_grant = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 0);

    for (int i = 0; i < 40; i++) begin
      ra = pick();
      rb = pick();
      rs = 1'($urandom_range(1));
      run_op(ra, rb, rs, 75, -1, 0, -1, lat, res);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
